// File: rtl/swipt_pkg.sv
// Shared constants and types for the SWIPT carrier link.
// Used by both the receive demodulator and the transmit-side driver.
package swipt_pkg;

    localparam int unsigned CLK_F   = 100_000_000;
    localparam int unsigned PeriodW = 13;
    localparam int unsigned HighW   = 12;
    localparam int unsigned ByteW   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } meas_state_e;

endpackage

// File: rtl/swipt_rx_sync.sv
// Two-flop synchronizer followed by a level deglitcher.
// Rising and falling edges both see 2+GLITCH cycles of latency, so measured widths are preserved.
module swipt_rx_sync #(
    parameter int unsigned GLITCH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CntW = (GLITCH > 1) ? $clog2(GLITCH) : 1;

    logic            meta_q;
    logic            sync_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= '0;
            dout   <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            // Any sample that matches the current output restarts the run.
            if (sync_q == dout) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(GLITCH - 1)) begin
                dout  <= sync_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/swipt_rx_demod.sv
// SWIPT receive demodulator: measures carrier period/high time, tracks lock,
// and decodes pulse-width bits into bytes with a valid/ready output.
module swipt_rx_demod #(
    parameter int unsigned CLK_F      = swipt_pkg::CLK_F,
    parameter int unsigned GLITCH     = 3,
    parameter int unsigned MIN_PERIOD = 100,
    parameter int unsigned MAX_PERIOD = 8000,
    parameter int unsigned LOCK_CNT   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_in,
    input  logic [11:0]                   thresh_l,
    output logic [swipt_pkg::PeriodW-1:0] period_cyc,
    output logic [swipt_pkg::HighW-1:0]   high_cyc,
    output logic                          meas_valid,
    output logic                          lock,
    output logic [swipt_pkg::ByteW-1:0]   data_byte,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic                          overrun
);

    import swipt_pkg::*;

    // CLK_F is informational; MAX_PERIOD must fit the 13-bit period counter.
    logic unused_clk_f;
    assign unused_clk_f = ^CLK_F;

    logic              filt;
    logic              filt_q;
    meas_state_e       state_q;
    logic [PeriodW-1:0] period_cnt_q;
    logic [HighW-1:0]  high_cnt_q;
    logic [7:0]        valid_cnt_q;
    logic              in_frame_q;
    logic [2:0]        bit_cnt_q;
    logic [ByteW-1:0]  shift_q;

    logic              rise, fall, close, timeout, accept, lose_track;
    logic              period_ok, at_max, lock_next, bit_one, frame_bit, byte_done;
    logic [24:0]       high_prod, thresh_prod;
    logic [ByteW-1:0]  byte_new;

    swipt_rx_sync #(
        .GLITCH(GLITCH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .din (rx_in),
        .dout(filt)
    );

    always_comb begin
        rise        = filt & ~filt_q;
        fall        = ~filt & filt_q;
        period_ok   = period_cnt_q >= PeriodW'(MIN_PERIOD);
        at_max      = period_cnt_q == PeriodW'(MAX_PERIOD);
        close       = (state_q == StLow) && rise;
        timeout     = (state_q != StIdle) && at_max && !close;
        accept      = close && period_ok;
        lose_track  = timeout || (close && !period_ok);
        lock_next   = ({1'b0, valid_cnt_q} + 9'd1) >= 9'(LOCK_CNT);
        high_prod   = 25'(high_cnt_q) * 25'd1000;
        thresh_prod = 25'(thresh_l) * 25'(period_cnt_q);
        bit_one     = high_prod >= thresh_prod;
        // Framing follows the lock state held before this period closed.
        frame_bit   = accept && lock;
        byte_done   = frame_bit && in_frame_q && (bit_cnt_q == 3'd7);
        byte_new    = {shift_q[ByteW-2:0], bit_one};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q       <= 1'b0;
            state_q      <= StIdle;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            valid_cnt_q  <= '0;
            in_frame_q   <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            period_cyc   <= '0;
            high_cyc     <= '0;
            meas_valid   <= 1'b0;
            lock         <= 1'b0;
            data_byte    <= '0;
            data_valid   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            filt_q     <= filt;
            meas_valid <= 1'b0;
            if (data_valid && data_ready) data_valid <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_q      <= StHigh;
                        period_cnt_q <= PeriodW'(1);
                        high_cnt_q   <= HighW'(1);
                    end
                end
                StHigh: begin
                    if (timeout) begin
                        state_q      <= StIdle;
                        period_cnt_q <= '0;
                        high_cnt_q   <= '0;
                    end else begin
                        period_cnt_q <= period_cnt_q + 1'b1;
                        if (fall) state_q <= StLow;
                        else if (high_cnt_q != '1) high_cnt_q <= high_cnt_q + 1'b1;
                    end
                end
                StLow: begin
                    if (close) begin
                        state_q      <= StHigh;
                        period_cnt_q <= PeriodW'(1);
                        high_cnt_q   <= HighW'(1);
                    end else if (timeout) begin
                        state_q      <= StIdle;
                        period_cnt_q <= '0;
                        high_cnt_q   <= '0;
                    end else begin
                        period_cnt_q <= period_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (accept) begin
                period_cyc <= period_cnt_q;
                high_cyc   <= high_cnt_q;
                meas_valid <= 1'b1;
                if (valid_cnt_q < 8'(LOCK_CNT)) valid_cnt_q <= valid_cnt_q + 1'b1;
                if (lock_next) lock <= 1'b1;
            end

            if (lose_track) begin
                lock        <= 1'b0;
                valid_cnt_q <= '0;
                in_frame_q  <= 1'b0;
                bit_cnt_q   <= '0;
            end

            if (frame_bit) begin
                if (!in_frame_q) begin
                    if (!bit_one) begin
                        in_frame_q <= 1'b1;
                        bit_cnt_q  <= '0;
                    end
                end else begin
                    shift_q   <= byte_new;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) in_frame_q <= 1'b0;
                end
            end

            // A same-cycle accept frees the slot, so the new byte replaces it.
            if (byte_done) begin
                if (!data_valid || data_ready) begin
                    data_byte  <= byte_new;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
